// File: rtl/conga_pkg.sv
// Shared types and default beat-counter constants for the conga game controller.
// Used with or without CONGA_STREAK_EN; the streak feature lives entirely in conga_round_ctrl.
package conga_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARM   = 3'd1,
        ST_RUN   = 3'd2,
        ST_JUDGE = 3'd3,
        ST_GAP   = 3'd4,
        ST_OVER  = 3'd5
    } conga_state_t;

    // Beat counter terminal value; the counter itself uses this same constant.
    localparam logic [15:0] CONGA_MAXCOUNT   = 16'd39648;
    localparam logic [15:0] CONGA_HIT_LO     = 16'd18000;
    localparam logic [15:0] CONGA_HIT_HI     = 16'd21648;
    localparam logic [15:0] CONGA_GAP_CYCLES = 16'd5000;

    function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [1:0] b);
        logic [8:0] s;
        s = {1'b0, a} + {7'd0, b};
        return s[8] ? 8'hFF : s[7:0];
    endfunction

endpackage

// File: rtl/conga_hit_judge.sv
// Hit-window judge: compares the beat count against the good-hit window and
// latches good/miss on the cycle the round leaves RUN.
module conga_hit_judge
    import conga_pkg::*;
#(
    parameter logic [15:0] MAXCOUNT = CONGA_MAXCOUNT,
    parameter logic [15:0] HIT_LO   = CONGA_HIT_LO,
    parameter logic [15:0] HIT_HI   = CONGA_HIT_HI
) (
    input  logic        i_clk,
    input  logic        i_resetn,
    input  logic        i_run,
    input  logic        i_hit,
    input  logic [15:0] i_count,
    output logic        o_done,
    output logic        o_good
);

    logic w_in_window;
    logic w_at_max;
    logic r_good;

    assign w_in_window = (i_count >= HIT_LO) && (i_count <= HIT_HI);
    assign w_at_max    = (i_count == MAXCOUNT);

    // A hit in the terminal-count cycle takes priority and is judged by the window.
    assign o_done = i_run && (i_hit || w_at_max);

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            r_good <= 1'b0;
        end else if (o_done) begin
            r_good <= i_hit && w_in_window;
        end
    end

    assign o_good = r_good;

endmodule

// File: rtl/conga_round_ctrl.sv
// Conga game-round sequencer: drives the beat counter, judges hits, tracks
// round/score/lives. Optional macro CONGA_STREAK_EN adds a 4-in-a-row bonus and o_streak.
module conga_round_ctrl
    import conga_pkg::*;
#(
    parameter logic [15:0] MAXCOUNT    = CONGA_MAXCOUNT,
    parameter logic [15:0] HIT_LO      = CONGA_HIT_LO,
    parameter logic [15:0] HIT_HI      = CONGA_HIT_HI,
    parameter int          NUM_ROUNDS  = 8,
    parameter int          START_LIVES = 3,
    parameter logic [15:0] GAP_CYCLES  = CONGA_GAP_CYCLES
) (
    input  logic        i_clk,
    input  logic        i_resetn,
    input  logic        i_start,
    input  logic        i_hit,
    input  logic [15:0] i_count,
    output logic        o_cnt_go,
    output logic        o_cnt_en,
    output logic [3:0]  o_round,
    output logic [7:0]  o_score,
    output logic [1:0]  o_lives,
    output logic        o_hit_good,
    output logic        o_hit_miss,
    output logic        o_busy,
    output logic        o_game_over,
    output logic        o_won
`ifdef CONGA_STREAK_EN
    ,
    output logic [1:0]  o_streak
`endif
);

    localparam logic [1:0] L_START_LIVES = 2'(START_LIVES);
    localparam logic [3:0] L_LAST_ROUND  = 4'(NUM_ROUNDS - 1);

    conga_state_t r_state;
    conga_state_t w_next_state;

    logic [3:0]  r_round;
    logic [7:0]  r_score;
    logic [1:0]  r_lives;
    logic        r_won;
    logic [15:0] r_gap;

    logic        w_done;
    logic        w_good;
    logic [1:0]  w_score_inc;
    logic [7:0]  w_score_upd;
    logic [1:0]  w_lives_after;
    logic        w_new_game;

    conga_hit_judge #(
        .MAXCOUNT (MAXCOUNT),
        .HIT_LO   (HIT_LO),
        .HIT_HI   (HIT_HI)
    ) u_judge (
        .i_clk    (i_clk),
        .i_resetn (i_resetn),
        .i_run    (r_state == ST_RUN),
        .i_hit    (i_hit),
        .i_count  (i_count),
        .o_done   (w_done),
        .o_good   (w_good)
    );

`ifdef CONGA_STREAK_EN
    logic [1:0] r_streak;

    // The good that wraps the streak 3->0 is the 4th in a row and earns the bonus.
    assign w_score_inc = (r_streak == 2'd3) ? 2'd2 : 2'd1;
    assign o_streak    = r_streak;

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            r_streak <= 2'd0;
        end else if (w_new_game) begin
            r_streak <= 2'd0;
        end else if (r_state == ST_JUDGE) begin
            r_streak <= w_good ? (r_streak + 2'd1) : 2'd0;
        end
    end
`else
    assign w_score_inc = 2'd1;
`endif

    assign w_score_upd   = sat_add8(r_score, w_score_inc);
    assign w_lives_after = w_good ? r_lives : (r_lives - 2'd1);
    assign w_new_game    = ((r_state == ST_IDLE) || (r_state == ST_OVER)) && i_start;

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE, ST_OVER: begin
                if (i_start) begin
                    w_next_state = ST_ARM;
                end
            end
            ST_ARM: begin
                w_next_state = ST_RUN;
            end
            ST_RUN: begin
                if (w_done) begin
                    w_next_state = ST_JUDGE;
                end
            end
            ST_JUDGE: begin
                if ((w_lives_after == 2'd0) || (r_round == L_LAST_ROUND)) begin
                    w_next_state = ST_OVER;
                end else begin
                    w_next_state = ST_GAP;
                end
            end
            ST_GAP: begin
                if (r_gap == 16'd0) begin
                    w_next_state = ST_ARM;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            r_round <= 4'd0;
            r_score <= 8'd0;
            r_lives <= L_START_LIVES;
            r_won   <= 1'b0;
            r_gap   <= 16'd0;
        end else if (w_new_game) begin
            r_round <= 4'd0;
            r_score <= 8'd0;
            r_lives <= L_START_LIVES;
            r_won   <= 1'b0;
        end else if (r_state == ST_JUDGE) begin
            if (w_good) begin
                r_score <= w_score_upd;
            end else begin
                r_lives <= w_lives_after;
            end
            if (w_lives_after == 2'd0) begin
                r_won <= 1'b0;
            end else if (r_round == L_LAST_ROUND) begin
                r_won <= 1'b1;
            end else begin
                r_round <= r_round + 4'd1;
                // GAP lasts GAP_CYCLES cycles: timer runs GAP_CYCLES-1 down to 0.
                r_gap   <= GAP_CYCLES - 16'd1;
            end
        end else if ((r_state == ST_GAP) && (r_gap != 16'd0)) begin
            r_gap <= r_gap - 16'd1;
        end
    end

    assign o_cnt_go    = (r_state == ST_ARM);
    assign o_cnt_en    = (r_state == ST_RUN);
    assign o_busy      = (r_state == ST_ARM) || (r_state == ST_RUN) ||
                         (r_state == ST_JUDGE) || (r_state == ST_GAP);
    assign o_game_over = (r_state == ST_OVER);
    assign o_hit_good  = (r_state == ST_JUDGE) && w_good;
    assign o_hit_miss  = (r_state == ST_JUDGE) && !w_good;
    assign o_round     = r_round;
    assign o_score     = r_score;
    assign o_lives     = r_lives;
    assign o_won       = r_won;

endmodule
